pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard and forwarding controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).
//  Tracks destination registers of in-flight instructions in EX, MEM and WB. Generates:
//    - load-use stalls and branch/jump flushes;
//    - registered forwarding selects for the EX-stage ALU operands.
//  Sits beside the control unit and drives the enables/clears of the pipeline registers.
// PARAMETERS
//  REG_AW   4   register-file address width (2**REG_AW registers)
//  R0_ZERO  1   1: register 0 is hardwired zero; rd==0 never creates a hazard or a forward
//  CNT_W    16  width of the saturating performance counters
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       asynchronous, active-low reset
//  id_valid       in   1       decode slot holds a real instruction
//  id_rs1         in   REG_AW  decode srcA register (instr[3:0])
//  id_rs2         in   REG_AW  decode srcB register (instr[7:4] or [11:8], per ri)
//  id_rs1_used    in   1       srcA is read by this instruction
//  id_rs2_used    in   1       srcB is a register, not an immediate
//  id_rd          in   REG_AW  decode destination register
//  id_wen         in   1       instruction writes the register file (wre)
//  id_is_load     in   1       result comes from RAM (wbs selects memData)
//  ex_redirect    in   1       branch/jump resolved taken in EX (ni)
//  stall          out  1       hold PC and the FetchDecode register (combinational)
//  bubble         out  1       load a NOP into the DecodeExecute register (combinational)
//  flush          out  1       clear FetchDecode and DecodeExecute (combinational, = ex_redirect)
//  fwd_a          out  2       EX srcA source, registered: 00 regfile, 01 EX/MEM ALU result,
//                              10 MEM/WB result, 11 WB bypass latch
//  fwd_b          out  2       same encoding for srcB
//  stall_cnt      out  CNT_W   number of stall cycles, saturating
//  flush_cnt      out  CNT_W   number of flush events, saturating
// BEHAVIOUR
//  Tracking state
//   - Three slots: EX, MEM, WB. Each slot is {v, rd, wen, ld}; a slot is "live" when v & wen & !(R0_ZERO & rd==0).
//   - Each clk: WB<=MEM, MEM<=EX.
//   - EX loads: flush -> invalid; else stall -> invalid (bubble); else id_* fields with v=id_valid.
//  Load-use hazard
//   - Asserted when live EX slot has ld=1 and rd matches (id_rs1 & id_rs1_used) or (id_rs2 & id_rs2_used), with id_valid=1.
//   - Response: stall=1, bubble=1 for exactly one cycle.
//   - Next cycle the load is in MEM and the dependant is resolved by forwarding (10).
//  Forwarding
//   - Computed from the decode-stage operands and registered into fwd_a/fwd_b on the edge the instruction enters EX.
//   - Priority, youngest first: EX slot match -> 01; MEM slot match -> 10; WB slot match -> 11; else 00.
//   - Unused operand -> 00.
//   - On stall or flush the registered selects load 00 (bubble carries no forwarding).
//  Flush
//   - Has priority over stall in the same cycle: flush=1, stall=0, bubble=0.
//   - The stalled instruction is discarded.
//   - Latency 0: flush follows ex_redirect combinationally.
//  Counters
//   - stall_cnt +1 per stall cycle; flush_cnt +1 per flush cycle.
//   - Both saturate at 2**CNT_W-1 and never wrap.
//  Reset
//   - Async on rst=0: all slots invalid, fwd_a=fwd_b=00, counters 0.
//   - stall, bubble and flush evaluate to 0 while all slots are invalid and ex_redirect=0.
//   - Reset mid-stall drops the hazard immediately.
// TESTING
//  1. ADD r1 then ADD r2,r1,r3 back-to-back -> no stall; the consumer sees fwd_a=01 in EX.
//  2. LOAD r4 then ADD r5,r4,r4 -> one cycle stall=1/bubble=1, stall_cnt=1; consumer then sees fwd_a=fwd_b=10.
//  3. Writer r6, two independent instructions, reader of r6 -> fwd=11.
//     Same test with writer to r0 (R0_ZERO=1) -> fwd=00, no stall.
//  4. Load-use hazard and ex_redirect=1 in the same cycle -> flush=1, stall=0, EX slot invalid, flush_cnt=1, stall_cnt unchanged.
//  5. Writers to r7 in EX and MEM at once, reader of r7 -> fwd_a=01 (youngest wins).
//  6. CNT_W=4, 20 load-use stalls -> stall_cnt holds at 15.
//     Assert rst=0 mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and forwarding controller for the 5-stage pipelined CPU
// (IF/ID/EX/MEM/WB). It tracks the destination registers of the instructions
// in flight in EX, MEM and WB. From these it produces load-use stalls,
// branch/jump flushes and registered forwarding selects for the EX-stage ALU
// operands. It also keeps two saturating performance counters.
//
// Parameters
//   REG_AW   register-file address width (2**REG_AW registers)
//   R0_ZERO  1: register 0 is hardwired zero and never creates a hazard or a forward
//   CNT_W    width of the saturating stall/flush counters
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   id_valid     decode slot holds a real instruction
//   id_rs1       decode source A register
//   id_rs2       decode source B register
//   id_rs1_used  source A is read by this instruction
//   id_rs2_used  source B is a register, not an immediate
//   id_rd        decode destination register
//   id_wen       instruction writes the register file
//   id_is_load   result comes from data memory
//   ex_redirect  branch/jump resolved taken in EX
//   stall        hold PC and the FetchDecode register (combinational)
//   bubble       load a NOP into the DecodeExecute register (combinational)
//   flush        clear FetchDecode and DecodeExecute (combinational)
//   fwd_a/fwd_b  registered EX operand source: 00 regfile, 01 EX/MEM ALU result,
//                10 MEM/WB result, 11 WB bypass latch
//   stall_cnt    saturating count of stall cycles
//   flush_cnt    saturating count of flush cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 4,
  parameter int R0_ZERO = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              ld;
  } slot_t;

  slot_t ex_q, mem_q, wb_q;
  slot_t id_slot;
  logic  hazard;
  logic  [1:0] fwd_a_d, fwd_b_d;

  // A slot only matters when it will really write a register; writes to a
  // hardwired-zero r0 are ignored.
  function automatic logic is_live(input slot_t s);
    return s.v & s.wen & ~((R0_ZERO != 0) & (s.rd == '0));
  endfunction

  // Youngest producer wins: the EX instruction's result is the newest value.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic used);
    logic [1:0] sel;
    sel = 2'b00;
    if (used) begin
      if (is_live(ex_q) && ex_q.rd == rs)
        sel = 2'b01;
      else if (is_live(mem_q) && mem_q.rd == rs)
        sel = 2'b10;
      else if (is_live(wb_q) && wb_q.rd == rs)
        sel = 2'b11;
    end
    return sel;
  endfunction

  // Load-use detection, flush priority and next forwarding selects.
  always_comb begin
    hazard  = 1'b0;
    id_slot = '0;
    if (id_valid && is_live(ex_q) && ex_q.ld) begin
      if ((id_rs1_used && id_rs1 == ex_q.rd) || (id_rs2_used && id_rs2 == ex_q.rd))
        hazard = 1'b1;
    end
    flush   = ex_redirect;
    stall   = hazard & ~ex_redirect;
    bubble  = stall;
    fwd_a_d = fwd_sel(id_rs1, id_rs1_used);
    fwd_b_d = fwd_sel(id_rs2, id_rs2_used);
    id_slot.v   = id_valid;
    id_slot.rd  = id_rd;
    id_slot.wen = id_wen;
    id_slot.ld  = id_is_load;
  end

  // Tracking slots and forwarding selects. A stalled or flushed decode slot
  // enters EX as an empty bubble that carries no forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (flush || stall) begin
        ex_q  <= '0;
        fwd_a <= 2'b00;
        fwd_b <= 2'b00;
      end else begin
        ex_q  <= id_slot;
        fwd_a <= fwd_a_d;
        fwd_b <= fwd_b_d;
      end
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl. Two instances share all inputs:
// one with the default 16-bit counters and one with 4-bit counters, so that
// counter saturation is reachable quickly. A behavioural model keeps the
// three in-flight instructions as a small history array (youngest first) and
// derives every expected output from the hazard/forwarding rules.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int AW  = 4;
  localparam int CW  = 16;
  localparam int CW4 = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_rs1_used, id_rs2_used, id_wen, id_is_load, ex_redirect;

  logic           stall, bubble, flush;
  logic [1:0]     fwd_a, fwd_b;
  logic [CW-1:0]  stall_cnt, flush_cnt;
  logic           stall4, bubble4, flush4;
  logic [1:0]     fwd_a4, fwd_b4;
  logic [CW4-1:0] stall_cnt4, flush_cnt4;

  pipe_hazard_ctrl #(.REG_AW(AW), .R0_ZERO(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_wen(id_wen), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .stall(stall), .bubble(bubble), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_AW(AW), .R0_ZERO(1), .CNT_W(CW4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_wen(id_wen), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .stall(stall4), .bubble(bubble4), .flush(flush4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: history of issued instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit v;
    int rd;
    bit wen;
    bit ld;
  } inst_t;

  inst_t hist[3];
  int    mFwdA, mFwdB, mStalls, mFlushes;

  typedef struct {
    bit v;
    int rs1, rs2;
    bit u1, u2;
    int rd;
    bit wen, ld, redir;
    int eStall, eFlush, eFa, eFb;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd,
                              bit wen, bit ld, bit redir,
                              int eStall, int eFlush, int eFa, int eFb);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd;
    t.wen = wen; t.ld = ld; t.redir = redir;
    t.eStall = eStall; t.eFlush = eFlush; t.eFa = eFa; t.eFb = eFb;
    return t;
  endfunction

  function automatic bit writesReg(int i);
    return hist[i].v && hist[i].wen && hist[i].rd != 0;
  endfunction

  function automatic bit expHazard();
    if (!id_valid || !writesReg(0) || !hist[0].ld) return 1'b0;
    return (id_rs1_used && int'(id_rs1) == hist[0].rd) ||
           (id_rs2_used && int'(id_rs2) == hist[0].rd);
  endfunction

  function automatic int expFwd(int rs, bit used);
    if (!used) return 0;
    for (int i = 0; i < 3; i++)
      if (writesReg(i) && hist[i].rd == rs) return i + 1;
    return 0;
  endfunction

  function automatic int sat(int value, int width);
    int maxv;
    maxv = (1 << width) - 1;
    return (value > maxv) ? maxv : value;
  endfunction

  task automatic checkValue(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) hist[i] = '{v: 1'b0, rd: 0, wen: 1'b0, ld: 1'b0};
    mFwdA = 0; mFwdB = 0; mStalls = 0; mFlushes = 0;
  endtask

  // Advances the model across the coming rising edge using the driven inputs.
  task automatic modelStep();
    bit doFlush, doStall;
    int nFa, nFb;
    doFlush = ex_redirect;
    doStall = expHazard() && !doFlush;
    nFa = expFwd(int'(id_rs1), id_rs1_used);
    nFb = expFwd(int'(id_rs2), id_rs2_used);
    if (doStall) mStalls++;
    if (doFlush) mFlushes++;
    mFwdA = (doStall || doFlush) ? 0 : nFa;
    mFwdB = (doStall || doFlush) ? 0 : nFb;
    hist[2] = hist[1];
    hist[1] = hist[0];
    if (doStall || doFlush)
      hist[0] = '{v: 1'b0, rd: 0, wen: 1'b0, ld: 1'b0};
    else
      hist[0] = '{v: id_valid, rd: int'(id_rd), wen: id_wen, ld: id_is_load};
  endtask

  task automatic applyStimulus(input bit v, input int rs1, input int rs2, input bit u1,
                               input bit u2, input int rd, input bit wen, input bit ld,
                               input bit redir);
    @(negedge clk);
    id_valid    = v;
    id_rs1      = AW'(rs1);
    id_rs2      = AW'(rs2);
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_rd       = AW'(rd);
    id_wen      = wen;
    id_is_load  = ld;
    ex_redirect = redir;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    int eStall;
    eStall = (expHazard() && !ex_redirect) ? 1 : 0;
    checkValue({tag, "_stall"},  int'(stall),  eStall);
    checkValue({tag, "_bubble"}, int'(bubble), eStall);
    checkValue({tag, "_flush"},  int'(flush),  int'(ex_redirect));
    checkValue({tag, "_fwd_a"},  int'(fwd_a),  mFwdA);
    checkValue({tag, "_fwd_b"},  int'(fwd_b),  mFwdB);
    checkValue({tag, "_stall4"}, int'(stall4), eStall);
    checkValue({tag, "_fwd_a4"}, int'(fwd_a4), mFwdA);
    checkValue({tag, "_stall_cnt"},  int'(stall_cnt),  sat(mStalls, CW));
    checkValue({tag, "_flush_cnt"},  int'(flush_cnt),  sat(mFlushes, CW));
    checkValue({tag, "_stall_cnt4"}, int'(stall_cnt4), sat(mStalls, CW4));
    checkValue({tag, "_flush_cnt4"}, int'(flush_cnt4), sat(mFlushes, CW4));
  endtask

  task automatic runCycle(input string tag, input bit v, input int rs1, input int rs2,
                          input bit u1, input bit u2, input int rd, input bit wen,
                          input bit ld, input bit redir);
    applyStimulus(v, rs1, rs2, u1, u2, rd, wen, ld, redir);
    checkOutput(tag);
    modelStep();
  endtask

  initial begin
    // Directed sequences; expected fwd values belong to the instruction
    // currently in EX, i.e. the previous row.
    // test 1: ADD r1 ; ADD r2,r1,r3
    vecs[0]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 3, 1, 1, 2, 1, 0, 0,  0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    // test 2: LOAD r4 ; ADD r5,r4,r4 (stalls once, then forwards from MEM)
    vecs[3]  = mk(1, 0, 0, 0, 0, 4, 1, 1, 0,  0, 0, 0, 0);
    vecs[4]  = mk(1, 4, 4, 1, 1, 5, 1, 0, 0,  1, 0, 0, 0);
    vecs[5]  = mk(1, 4, 4, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 2);
    // test 3: writer r6, two independent, reader of r6
    vecs[7]  = mk(1, 0, 0, 0, 0, 6, 1, 0, 0,  0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 8, 1, 0, 0,  0, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  0, 0, 0, 0);
    vecs[10] = mk(1, 6, 6, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3, 3);
    // same with writer to r0, then load r0 followed by a reader of r0
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 0, 8, 1, 0, 0,  0, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  0, 0, 0, 0);
    vecs[15] = mk(1, 0, 0, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[17] = mk(1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0);
    vecs[18] = mk(1, 0, 0, 1, 0, 11, 1, 0, 0, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // test 5: writers to r7 in EX and MEM, reader of r7
    vecs[20] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0,  0, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0,  0, 0, 0, 0);
    vecs[22] = mk(1, 7, 3, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    // test 4: load-use hazard together with a redirect
    vecs[24] = mk(1, 0, 0, 0, 0, 4, 1, 1, 0,  0, 0, 0, 0);
    vecs[25] = mk(1, 4, 0, 1, 0, 5, 1, 0, 1,  0, 1, 0, 0);
    vecs[26] = mk(1, 4, 0, 1, 0, 5, 1, 0, 0,  0, 0, 0, 0);
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0);

    modelReset();
    rst = 1'b0;
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = '0; id_wen = 0; id_is_load = 0; ex_redirect = 0;
    #12;
    checkOutput("reset");
    rst = 1'b1;
    modelStep();

    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                    vecs[i].rd, vecs[i].wen, vecs[i].ld, vecs[i].redir);
      checkValue($sformatf("v%0d_stall", i), int'(stall), vecs[i].eStall);
      checkValue($sformatf("v%0d_flush", i), int'(flush), vecs[i].eFlush);
      checkValue($sformatf("v%0d_fwd_a", i), int'(fwd_a), vecs[i].eFa);
      checkValue($sformatf("v%0d_fwd_b", i), int'(fwd_b), vecs[i].eFb);
      checkOutput($sformatf("v%0d", i));
      modelStep();
    end
    checkValue("table_stall_cnt", int'(stall_cnt), 1);
    checkValue("table_flush_cnt", int'(flush_cnt), 1);

    // 20 load-use stalls: the 4-bit counter must stick at 15.
    for (int i = 0; i < 20; i++) begin
      runCycle("sat_ld", 1, 0, 0, 0, 0, 4, 1, 1, 0);
      runCycle("sat_use", 1, 4, 0, 1, 0, 5, 1, 0, 0);
    end
    runCycle("sat_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkValue("sat_stall_cnt4", int'(stall_cnt4), 15);
    checkValue("sat_stall_cnt16", int'(stall_cnt), 21);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      runCycle("rnd", $urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) == 0);
    end

    // Reset asserted in the middle of a load-use stall.
    runCycle("mr_ld", 1, 0, 0, 0, 0, 4, 1, 1, 0);
    applyStimulus(1, 4, 4, 1, 1, 5, 1, 0, 0);
    checkValue("mr_pre_stall", int'(stall), 1);
    #1 rst = 1'b0;
    #1;
    modelReset();
    checkValue("mr_stall",  int'(stall),  0);
    checkValue("mr_bubble", int'(bubble), 0);
    checkValue("mr_flush",  int'(flush),  0);
    checkValue("mr_fwd_a",  int'(fwd_a),  0);
    checkValue("mr_fwd_b",  int'(fwd_b),  0);
    checkValue("mr_stall_cnt",  int'(stall_cnt),  0);
    checkValue("mr_flush_cnt",  int'(flush_cnt),  0);
    checkValue("mr_stall_cnt4", int'(stall_cnt4), 0);
    @(negedge clk);
    id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_wen = 0; id_is_load = 0;
    rst = 1'b1;
    modelStep();
    runCycle("post_rst", 1, 4, 0, 1, 0, 5, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
